// File: rtl/lcd_text_buf_if.sv
// Host write stream and LCD driver read port of the character frame buffer.
// The master side is the host/driver, the slave side is lcd_text_buf.
interface lcd_text_buf_if;
    logic       WR_VALID_I;
    logic [7:0] WR_DATA_I;
    logic       WR_READY_O;
    logic       RD_EN_I;
    logic [9:0] RD_ADDR_I;
    logic [7:0] RD_CHR_O;
    logic [5:0] CURSOR_O;
    logic       BUSY_O;

    modport master (
        output WR_VALID_I, WR_DATA_I, RD_EN_I, RD_ADDR_I,
        input  WR_READY_O, RD_CHR_O, CURSOR_O, BUSY_O
    );

    modport slave (
        input  WR_VALID_I, WR_DATA_I, RD_EN_I, RD_ADDR_I,
        output WR_READY_O, RD_CHR_O, CURSOR_O, BUSY_O
    );
endinterface

// File: rtl/lcd_text_buf.sv
// 40-byte character frame buffer for a two-line LCD16032 display.
// Decodes a host byte stream (ASCII, GB2312 double-byte, CR/LF/BS/FF),
// keeps double-byte characters on even/odd address pairs, and serves
// the image to the LCD driver through a registered, read-first port.
module lcd_text_buf #(
    parameter logic [7:0] C_BLANK = 8'h20
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    lcd_text_buf_if.slave  bus
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    localparam logic [5:0] LAST_IDX  = 6'd39;
    localparam logic [5:0] LINE2_IDX = 6'd20;

    logic [1:0] state_q,   state_d;
    logic [5:0] clr_idx_q, clr_idx_d;
    logic [5:0] cursor_q,  cursor_d;
    logic       hz_pend_q, hz_pend_d;
    logic [7:0] lead_q,    lead_d;
    logic       ready_q,   ready_d;
    logic [7:0] rd_chr_q;
    logic [7:0] mem_q [0:39];

    logic       mem_we_d;
    logic [5:0] mem_addr_d;
    logic [7:0] mem_wdata_d;
    logic       accept_s;

    // Cursor step forward with wrap 39 -> 0.
    function automatic logic [5:0] cur_inc(input logic [5:0] c);
        return (c == LAST_IDX) ? 6'd0 : (c + 6'd1);
    endfunction

    // Cursor step backward with wrap 0 -> 39.
    function automatic logic [5:0] cur_dec(input logic [5:0] c);
        return (c == 6'd0) ? LAST_IDX : (c - 6'd1);
    endfunction

    assign accept_s = bus.WR_VALID_I & ready_q;

    // Next-state, RAM write port and byte decode.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cursor_d    = cursor_q;
        hz_pend_d   = hz_pend_q;
        lead_d      = lead_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = cursor_q;
        mem_wdata_d = bus.WR_DATA_I;
        case (state_q)
            ST_CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_idx_q;
                mem_wdata_d = C_BLANK;
                if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = 6'd0;
                    cursor_d  = 6'd0;
                    hz_pend_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 6'd1;
                end
            end
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (hz_pend_q) begin
                    // Trail byte of a double-byte character: any value.
                    mem_we_d  = 1'b1;
                    cursor_d  = cur_inc(cursor_q);
                    hz_pend_d = 1'b0;
                end else if (bus.WR_DATA_I[7]) begin
                    if (!cursor_q[0]) begin
                        mem_we_d  = 1'b1;
                        cursor_d  = cur_inc(cursor_q);
                        hz_pend_d = 1'b1;
                    end else begin
                        // Lead byte on an odd cell: blank it, write lead next cycle.
                        mem_we_d    = 1'b1;
                        mem_wdata_d = C_BLANK;
                        cursor_d    = cur_inc(cursor_q);
                        lead_d      = bus.WR_DATA_I;
                        state_d     = ST_PAD;
                    end
                end else if (bus.WR_DATA_I >= 8'h20 && bus.WR_DATA_I != 8'h7F) begin
                    mem_we_d = 1'b1;
                    cursor_d = cur_inc(cursor_q);
                end else begin
                    case (bus.WR_DATA_I)
                        8'h0C: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = 6'd0;
                        end
                        8'h0D:   cursor_d = (cursor_q < LINE2_IDX) ? 6'd0 : LINE2_IDX;
                        8'h0A:   cursor_d = (cursor_q < LINE2_IDX) ? LINE2_IDX : 6'd0;
                        8'h08:   cursor_d = cur_dec(cursor_q);
                        default: cursor_d = cursor_q;
                    endcase
                end
            end
            ST_PAD: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = lead_q;
                cursor_d    = cur_inc(cursor_q);
                hz_pend_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = 6'd0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Control state registers; reset restarts the clear sequence.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= 6'd0;
            cursor_q  <= 6'd0;
            hz_pend_q <= 1'b0;
            lead_q    <= 8'h00;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cursor_q  <= cursor_d;
            hz_pend_q <= hz_pend_d;
            lead_q    <= lead_d;
            ready_q   <= ready_d;
        end
    end

    // Character RAM write port.
    always_ff @(posedge CLK_I) begin
        if (!RST_I && mem_we_d) begin
            mem_q[mem_addr_d] <= mem_wdata_d;
        end
    end

    // Registered read port; read-first against a same-edge write.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rd_chr_q <= C_BLANK;
        end else if (bus.RD_EN_I) begin
            if (bus.RD_ADDR_I < 10'd40) begin
                rd_chr_q <= mem_q[bus.RD_ADDR_I[5:0]];
            end else begin
                rd_chr_q <= C_BLANK;
            end
        end
    end

    assign bus.WR_READY_O = ready_q;
    assign bus.BUSY_O     = ~ready_q;
    assign bus.CURSOR_O   = cursor_q;
    assign bus.RD_CHR_O   = rd_chr_q;

endmodule
